compute_burst: RTL and testbench
================================

# compute_burst

Parametrised burst successor to the single-word add-by-one compute engine in the tsim example accelerator. On launch it streams `length` words from `inp_baddr` to `out_baddr` in bursts of up to `BURST_LEN` words, applying a runtime-selected ALU operation to each word. It adds request/write back-pressure and burst-length generation. It sits between the host register file (launch/finish/config) and the tsim memory port.

## Interface
- MEM_LEN_BITS, 8, width of mem_req_len (beats minus one)
- MEM_ADDR_BITS, 64, memory byte-address width
- MEM_DATA_BITS, 64, word width; must be a multiple of 8
- HOST_DATA_BITS, 32, width of length and operand
- BURST_LEN, 8, max words per burst; 1 ≤ BURST_LEN ≤ 2^MEM_LEN_BITS; also the local buffer depth

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  request accepted when valid&ready
- mem_req_opcode  out  1  0 read, 1 write
- mem_req_len  out  MEM_LEN_BITS  beats−1 of this burst
- mem_req_addr  out  MEM_ADDR_BITS  burst start byte address
- mem_wr_valid  out  1  write beat valid
- mem_wr_ready  in  1  write beat accepted when valid&ready
- mem_wr_bits  out  MEM_DATA_BITS  write data
- mem_rd_valid  in  1  read beat valid
- mem_rd_bits  in  MEM_DATA_BITS  read data
- mem_rd_ready  out  1  read beat accepted when valid&ready
- launch  in  1  start; sampled only in IDLE
- finish  out  1  one-cycle completion pulse
- length  in  HOST_DATA_BITS  word count
- mode  in  2  0 add, 1 subtract, 2 xor, 3 pass-through
- operand  in  HOST_DATA_BITS  ALU operand, zero-extended to MEM_DATA_BITS
- inp_baddr  in  MEM_ADDR_BITS  source base byte address
- out_baddr  in  MEM_ADDR_BITS  destination base byte address

## Operation
- States: IDLE, READ_REQ, READ_DATA, WRITE_REQ, WRITE_DATA, FINISH.
- IDLE, launch=1: latch length, mode, operand and both base addresses. Clear cnt. Go to READ_REQ, or to FINISH if length==0. Config inputs are don't-care after launch.
- Burst beats: beats = min(length−cnt, BURST_LEN). mem_req_len = beats−1, held constant for the read and write request of the burst.
- READ_REQ: mem_req_valid=1, opcode=0, addr=raddr. Leave on the req handshake to READ_DATA; beat index = 0.
- READ_DATA: mem_rd_ready=1. On each rd handshake, write f(mem_rd_bits) into buf[index] and increment index. After beat `beats` go to WRITE_REQ.
- f: add is x+op and subtract is x−op, both modulo 2^MEM_DATA_BITS (wrap, no saturation). xor is x^op. Pass-through is x.
- WRITE_REQ: mem_req_valid=1, opcode=1, addr=waddr. On the handshake go to WRITE_DATA; index = 0.
- WRITE_DATA: mem_wr_valid=1, mem_wr_bits=buf[index]. On each wr handshake increment index. On the last beat:
  - cnt += beats
  - raddr and waddr each += beats·(MEM_DATA_BITS/8)
  - go to FINISH if the new cnt==length, else to READ_REQ
- FINISH: finish=1 for exactly one cycle, then IDLE.
- mem_req_addr shows raddr in READ_REQ and waddr otherwise. Addresses wrap modulo 2^MEM_ADDR_BITS.
- launch outside IDLE is ignored. Read beats arriving outside READ_DATA are not accepted (mem_rd_ready=0).

## Timing
- Reset (asynchronous, immediate) clears:
  - state=IDLE
  - cnt, index, raddr, waddr, buffer and latched config → 0
  - all outputs 0
- Reset mid-burst abandons the transfer with no finish pulse; the memory side is expected to be reset together with this block.
- All outputs are decoded from registered state and registers; there are no combinational paths from inputs to outputs.
- The request is held stable (valid, opcode, len, addr) until ready. wr_valid/wr_bits are held until wr_ready.
- Minimum burst latency, with ready always high and rd_valid back-to-back: 1 (READ_REQ) + beats + 1 (WRITE_REQ) + beats cycles.
- Total for length=N, ready always high: Σ(2·beats+2) + 1 FINISH cycle.
- Launch to finish with length==0: finish is asserted 1 cycle after the launch edge.

## Test plan
- length=4, BURST_LEN=8, mode=0, operand=1, inp=0x1000, out=0x2000, data 10..13, ready tied high:
  - one read and one write request, both len=3
  - writes 11..14 to 0x2000
  - finish after 1+4+1+4+1 cycles
- length=10, BURST_LEN=4, mode=3:
  - bursts with len=3,3,1
  - read addrs 0x1000/0x1020/0x1040, write addrs 0x2000/0x2020/0x2040
  - data passes through unchanged
- Wrap and subtract:
  - mode=0, operand=1, data 0xFFFF_FFFF_FFFF_FFFF → writes 0
  - mode=1, operand=2, data 1 → writes 0xFFFF_FFFF_FFFF_FFFF
- Back-pressure:
  - mem_req_ready low 3 cycles: request fields stay stable
  - mem_wr_ready toggling: each beat is held until accepted, with no duplicated or dropped beats
  - rd_valid gaps: no extra beats captured
- Edge cases:
  - length=0: finish pulse 1 cycle after launch, no mem_req_valid
  - launch held high during a run: no restart, exactly one finish per run
- Reset: reset_n asserted mid-READ_DATA (asynchronously, between edges):
  - outputs go to 0 immediately and no finish pulse
  - a new launch afterwards completes correctly

Source files
------------

// File: rtl/compute_burst.sv
`default_nettype none
// ============================================================================
// Module   : compute_burst
// Purpose  : Burst copy engine that streams words from a source to a
//            destination buffer, applying a selectable ALU op to each word.
// Revision : 1.0 - initial release
// ============================================================================
module compute_burst #(
    parameter int MEM_LEN_BITS   = 8,
    parameter int MEM_ADDR_BITS  = 64,
    parameter int MEM_DATA_BITS  = 64,
    parameter int HOST_DATA_BITS = 32,
    parameter int BURST_LEN      = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]   mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
    output logic                      mem_wr_valid,
    input  logic                      mem_wr_ready,
    output logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
    input  logic                      mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
    output logic                      mem_rd_ready,
    input  logic                      launch,
    output logic                      finish,
    input  logic [HOST_DATA_BITS-1:0] length,
    input  logic [1:0]                mode,
    input  logic [HOST_DATA_BITS-1:0] operand,
    input  logic [MEM_ADDR_BITS-1:0]  inp_baddr,
    input  logic [MEM_ADDR_BITS-1:0]  out_baddr
);

    localparam int c_IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [HOST_DATA_BITS-1:0] c_BURST      = HOST_DATA_BITS'(BURST_LEN);
    localparam logic [MEM_ADDR_BITS-1:0]  c_WORD_BYTES = MEM_ADDR_BITS'(MEM_DATA_BITS / 8);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READ_REQ   = 3'd1,
        READ_DATA  = 3'd2,
        WRITE_REQ  = 3'd3,
        WRITE_DATA = 3'd4,
        FINISH     = 3'd5
    } state_t;

    state_t                    r_state;
    logic [HOST_DATA_BITS-1:0] r_length;
    logic [HOST_DATA_BITS-1:0] r_operand;
    logic [HOST_DATA_BITS-1:0] r_cnt;
    logic [1:0]                r_mode;
    logic [MEM_ADDR_BITS-1:0]  r_raddr;
    logic [MEM_ADDR_BITS-1:0]  r_waddr;
    logic [MEM_LEN_BITS-1:0]   r_req_len;
    logic [MEM_LEN_BITS-1:0]   r_idx;
    logic [MEM_DATA_BITS-1:0]  r_buf [BURST_LEN];

    logic [c_IDX_W-1:0]        w_idx;
    logic                      w_last;
    logic [HOST_DATA_BITS-1:0] w_cnt_next;
    logic [MEM_ADDR_BITS-1:0]  w_addr_step;
    logic [MEM_DATA_BITS-1:0]  w_op;
    logic [MEM_DATA_BITS-1:0]  w_alu;

    // Burst size for the remaining word count, encoded as beats-1.
    function automatic logic [MEM_LEN_BITS-1:0] f_req_len(input logic [HOST_DATA_BITS-1:0] remain);
        logic [HOST_DATA_BITS-1:0] beats;
        beats = (remain < c_BURST) ? remain : c_BURST;
        beats = beats - HOST_DATA_BITS'(1);
        return beats[MEM_LEN_BITS-1:0];
    endfunction

    assign w_idx       = r_idx[c_IDX_W-1:0];
    assign w_last      = (r_idx == r_req_len);
    assign w_cnt_next  = r_cnt + HOST_DATA_BITS'(r_req_len) + HOST_DATA_BITS'(1);
    assign w_addr_step = (MEM_ADDR_BITS'(r_req_len) + MEM_ADDR_BITS'(1)) * c_WORD_BYTES;
    assign w_op        = MEM_DATA_BITS'(r_operand);

    always_comb begin
        w_alu = mem_rd_bits;
        case (r_mode)
            2'd0:    w_alu = mem_rd_bits + w_op;
            2'd1:    w_alu = mem_rd_bits - w_op;
            2'd2:    w_alu = mem_rd_bits ^ w_op;
            default: w_alu = mem_rd_bits;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_length  <= '0;
            r_operand <= '0;
            r_cnt     <= '0;
            r_mode    <= '0;
            r_raddr   <= '0;
            r_waddr   <= '0;
            r_req_len <= '0;
            r_idx     <= '0;
            for (int i = 0; i < BURST_LEN; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (launch) begin
                        r_length  <= length;
                        r_mode    <= mode;
                        r_operand <= operand;
                        r_raddr   <= inp_baddr;
                        r_waddr   <= out_baddr;
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        if (length == '0) begin
                            r_state <= FINISH;
                        end else begin
                            r_req_len <= f_req_len(length);
                            r_state   <= READ_REQ;
                        end
                    end
                end
                READ_REQ: begin
                    if (mem_req_ready) begin
                        r_idx   <= '0;
                        r_state <= READ_DATA;
                    end
                end
                READ_DATA: begin
                    if (mem_rd_valid) begin
                        r_buf[w_idx] <= w_alu;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= WRITE_REQ;
                        end else begin
                            r_idx <= r_idx + MEM_LEN_BITS'(1);
                        end
                    end
                end
                WRITE_REQ: begin
                    if (mem_req_ready) begin
                        r_idx   <= '0;
                        r_state <= WRITE_DATA;
                    end
                end
                WRITE_DATA: begin
                    if (mem_wr_ready) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_cnt   <= w_cnt_next;
                            r_raddr <= r_raddr + w_addr_step;
                            r_waddr <= r_waddr + w_addr_step;
                            if (w_cnt_next == r_length) begin
                                r_state <= FINISH;
                            end else begin
                                r_req_len <= f_req_len(r_length - w_cnt_next);
                                r_state   <= READ_REQ;
                            end
                        end else begin
                            r_idx <= r_idx + MEM_LEN_BITS'(1);
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registers, so reset drives them all low at once.
    assign mem_req_valid  = (r_state == READ_REQ) || (r_state == WRITE_REQ);
    assign mem_req_opcode = (r_state == WRITE_REQ);
    assign mem_req_len    = r_req_len;
    assign mem_req_addr   = (r_state == READ_REQ) ? r_raddr : r_waddr;
    assign mem_rd_ready   = (r_state == READ_DATA);
    assign mem_wr_valid   = (r_state == WRITE_DATA);
    assign mem_wr_bits    = r_buf[w_idx];
    assign finish         = (r_state == FINISH);

endmodule
`default_nettype wire

// File: tb/tb_compute_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_compute_burst
// Purpose  : Directed self-checking bench for compute_burst (BURST_LEN = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_compute_burst;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_req_valid, mem_req_ready, mem_req_opcode;
    logic [7:0]  mem_req_len;
    logic [63:0] mem_req_addr;
    logic        mem_wr_valid, mem_wr_ready;
    logic [63:0] mem_wr_bits;
    logic        mem_rd_valid, mem_rd_ready;
    logic [63:0] mem_rd_bits;
    logic        launch, finish;
    logic [31:0] length, operand;
    logic [1:0]  mode;
    logic [63:0] inp_baddr, out_baddr;

    always #5 clock = ~clock;

    compute_burst #(
        .MEM_LEN_BITS  (8),
        .MEM_ADDR_BITS (64),
        .MEM_DATA_BITS (64),
        .HOST_DATA_BITS(32),
        .BURST_LEN     (4)
    ) u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_opcode(mem_req_opcode),
        .mem_req_len   (mem_req_len),
        .mem_req_addr  (mem_req_addr),
        .mem_wr_valid  (mem_wr_valid),
        .mem_wr_ready  (mem_wr_ready),
        .mem_wr_bits   (mem_wr_bits),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_bits   (mem_rd_bits),
        .mem_rd_ready  (mem_rd_ready),
        .launch        (launch),
        .finish        (finish),
        .length        (length),
        .mode          (mode),
        .operand       (operand),
        .inp_baddr     (inp_baddr),
        .out_baddr     (out_baddr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mem [logic [63:0]];
    logic [63:0] rq_addr [$];
    logic [7:0]  rq_len  [$];
    logic        rq_op   [$];
    int          finish_cnt, fin_cycle, wr_total;
    int          req_stall   = 0;
    bit          wr_toggle   = 0;
    bit          rd_gap      = 0;
    bit          hold_launch = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_req(input string tag, input int i, input logic op,
                             input logic [7:0] len, input logic [63:0] addr);
        if (i < rq_addr.size()) begin
            check($sformatf("%s req%0d op", tag, i), rq_op[i], op);
            check($sformatf("%s req%0d len", tag, i), rq_len[i], len);
            check($sformatf("%s req%0d addr", tag, i), rq_addr[i], addr);
        end
    endtask

    // Launches one job and acts as the memory until a few cycles past finish.
    task automatic run_job(input string tag, input logic [31:0] j_len, input logic [1:0] j_mode,
                           input logic [31:0] j_op, input logic [63:0] j_in, input logic [63:0] j_out);
        int          rd_left, stall_ctr;
        logic [63:0] rd_a, wr_a, held, cap_addr;
        logic [8:0]  cap_lo;
        bit          req_seen, have_held;
        rd_left = 0; stall_ctr = 0; rd_a = '0; wr_a = '0; held = '0;
        cap_addr = '0; cap_lo = '0; req_seen = 0; have_held = 0;
        rq_addr.delete(); rq_len.delete(); rq_op.delete();
        finish_cnt = 0; fin_cycle = -1; wr_total = 0;
        @(negedge clock);
        length = j_len; mode = j_mode; operand = j_op;
        inp_baddr = j_in; out_baddr = j_out; launch = 1'b1;
        mem_req_ready = 1'b1; mem_wr_ready = 1'b1; mem_rd_valid = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clock);
            if (!hold_launch || finish) launch = 1'b0;
            length = '1; mode = 2'd1; operand = '1; inp_baddr = '1; out_baddr = '1;
            if (finish) begin
                finish_cnt++;
                if (fin_cycle < 0) fin_cycle = c;
            end
            if (rd_left > 0 && !(rd_gap && (c % 3 == 0))) begin
                mem_rd_valid = 1'b1;
                mem_rd_bits  = mem[rd_a];
            end else begin
                mem_rd_valid = 1'b0;
                mem_rd_bits  = '0;
            end
            if (mem_rd_valid && mem_rd_ready) begin
                rd_a += 64'd8;
                rd_left--;
            end
            if (mem_req_valid) begin
                if (!req_seen) begin
                    req_seen  = 1;
                    stall_ctr = req_stall;
                    cap_addr  = mem_req_addr;
                    cap_lo    = {mem_req_opcode, mem_req_len};
                end else begin
                    check({tag, " stall addr"}, mem_req_addr, cap_addr);
                    check({tag, " stall op/len"}, {mem_req_opcode, mem_req_len}, cap_lo);
                end
                mem_req_ready = (stall_ctr == 0);
                if (stall_ctr > 0) stall_ctr--;
                if (mem_req_ready) begin
                    rq_addr.push_back(mem_req_addr);
                    rq_len.push_back(mem_req_len);
                    rq_op.push_back(mem_req_opcode);
                    req_seen = 0;
                    if (!mem_req_opcode) begin
                        rd_a    = mem_req_addr;
                        rd_left = int'(mem_req_len) + 1;
                    end else begin
                        wr_a = mem_req_addr;
                    end
                end
            end else begin
                mem_req_ready = 1'b1;
            end
            mem_wr_ready = wr_toggle ? (c % 2 == 1) : 1'b1;
            if (have_held) begin
                check({tag, " wr held valid"}, mem_wr_valid, 1'b1);
                check({tag, " wr held bits"}, mem_wr_bits, held);
                have_held = 0;
            end
            if (mem_wr_valid) begin
                if (mem_wr_ready) begin
                    mem[wr_a] = mem_wr_bits;
                    wr_a += 64'd8;
                    wr_total++;
                end else begin
                    held      = mem_wr_bits;
                    have_held = 1;
                end
            end
            if (fin_cycle >= 0 && c >= fin_cycle + 3) break;
        end
        launch = 1'b0; mem_rd_valid = 1'b0; mem_req_ready = 1'b1; mem_wr_ready = 1'b1;
        check({tag, " finish count"}, finish_cnt, 1);
        check({tag, " write beats"}, wr_total, j_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fin;
        int beats;
        reset_n = 1'b0; launch = 1'b0; length = '0; mode = '0; operand = '0;
        inp_baddr = '0; out_baddr = '0; mem_req_ready = 1'b0; mem_wr_ready = 1'b0;
        mem_rd_valid = 1'b0; mem_rd_bits = '0;
        #12;
        check("reset req_valid", mem_req_valid, 1'b0);
        check("reset req_addr", mem_req_addr, 64'h0);
        check("reset req_len", mem_req_len, 8'h0);
        check("reset finish", finish, 1'b0);
        @(negedge clock); reset_n = 1'b1;

        // Single burst, add 1
        for (int i = 0; i < 4; i++) mem[64'h1000 + 64'(8 * i)] = 64'(10 + i);
        run_job("t1", 32'd4, 2'd0, 32'd1, 64'h1000, 64'h2000);
        check("t1 nreq", rq_addr.size(), 2);
        check_req("t1", 0, 1'b0, 8'd3, 64'h1000);
        check_req("t1", 1, 1'b1, 8'd3, 64'h2000);
        for (int i = 0; i < 4; i++) check($sformatf("t1 data%0d", i), mem[64'h2000 + 64'(8 * i)], 64'(11 + i));
        check("t1 latency", fin_cycle, 11);

        // Three bursts, pass-through
        for (int i = 0; i < 10; i++) mem[64'h1000 + 64'(8 * i)] = 64'hA0 + 64'(i);
        run_job("t2", 32'd10, 2'd3, 32'h55, 64'h1000, 64'h2000);
        check("t2 nreq", rq_addr.size(), 6);
        check_req("t2", 0, 1'b0, 8'd3, 64'h1000);
        check_req("t2", 1, 1'b1, 8'd3, 64'h2000);
        check_req("t2", 2, 1'b0, 8'd3, 64'h1020);
        check_req("t2", 3, 1'b1, 8'd3, 64'h2020);
        check_req("t2", 4, 1'b0, 8'd1, 64'h1040);
        check_req("t2", 5, 1'b1, 8'd1, 64'h2040);
        for (int i = 0; i < 10; i++) check($sformatf("t2 data%0d", i), mem[64'h2000 + 64'(8 * i)], 64'hA0 + 64'(i));
        check("t2 latency", fin_cycle, 27);

        // Wrap on add, borrow on subtract, xor
        mem[64'h3000] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_job("t3", 32'd1, 2'd0, 32'd1, 64'h3000, 64'h4000);
        check("t3 add wrap", mem[64'h4000], 64'h0);
        mem[64'h3000] = 64'h1;
        run_job("t4", 32'd1, 2'd1, 32'd2, 64'h3000, 64'h4000);
        check("t4 sub wrap", mem[64'h4000], 64'hFFFF_FFFF_FFFF_FFFF);
        mem[64'h3000] = 64'h1234_5678_9ABC_DEF0;
        mem[64'h3008] = 64'hFFFF_FFFF_0000_0000;
        run_job("t5", 32'd2, 2'd2, 32'hF0F0_F0F0, 64'h3000, 64'h4000);
        check("t5 xor0", mem[64'h4000], 64'h1234_5678_6A4C_2E00);
        check("t5 xor1", mem[64'h4008], 64'hFFFF_FFFF_F0F0_F0F0);

        // Back-pressure on every channel
        for (int i = 0; i < 6; i++) mem[64'h5000 + 64'(8 * i)] = 64'h10 + 64'(i);
        req_stall = 3; wr_toggle = 1; rd_gap = 1;
        run_job("t6", 32'd6, 2'd0, 32'h100, 64'h5000, 64'h6000);
        req_stall = 0; wr_toggle = 0; rd_gap = 0;
        check("t6 nreq", rq_addr.size(), 4);
        check_req("t6", 2, 1'b0, 8'd1, 64'h5020);
        check_req("t6", 3, 1'b1, 8'd1, 64'h6020);
        for (int i = 0; i < 6; i++) check($sformatf("t6 data%0d", i), mem[64'h6000 + 64'(8 * i)], 64'h110 + 64'(i));

        // Zero length
        run_job("t7", 32'd0, 2'd0, 32'd1, 64'h1000, 64'h2000);
        check("t7 nreq", rq_addr.size(), 0);
        check("t7 latency", fin_cycle, 1);

        // Launch held high throughout
        mem[64'h7000] = 64'h0123; mem[64'h7008] = 64'hFF00; mem[64'h7010] = 64'hAAAA;
        hold_launch = 1;
        run_job("t8", 32'd3, 2'd2, 32'hFF, 64'h7000, 64'h7800);
        hold_launch = 0;
        check("t8 nreq", rq_addr.size(), 2);
        check("t8 data0", mem[64'h7800], 64'h01DC);
        check("t8 data1", mem[64'h7808], 64'hFFFF);
        check("t8 data2", mem[64'h7810], 64'hAA55);

        // Asynchronous reset in the middle of READ_DATA
        @(negedge clock);
        length = 32'd8; mode = 2'd0; operand = 32'd1; inp_baddr = 64'h1000;
        out_baddr = 64'h9000; launch = 1'b1; mem_req_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 50 && beats < 2; c++) begin
            @(negedge clock);
            launch = 1'b0; mem_rd_valid = 1'b1; mem_rd_bits = 64'h77;
            if (mem_rd_valid && mem_rd_ready) beats++;
        end
        check("t9 beats before reset", beats, 2);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check("t9 rst rd_ready", mem_rd_ready, 1'b0);
        check("t9 rst req_valid", mem_req_valid, 1'b0);
        check("t9 rst wr_valid", mem_wr_valid, 1'b0);
        check("t9 rst req_len", mem_req_len, 8'h0);
        check("t9 rst req_addr", mem_req_addr, 64'h0);
        check("t9 rst wr_bits", mem_wr_bits, 64'h0);
        mem_rd_valid = 1'b0;
        fin = 0;
        repeat (3) begin
            @(negedge clock);
            if (finish) fin++;
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (finish) fin++;
        end
        check("t9 no finish", fin, 0);
        check("t9 idle after reset", mem_req_valid, 1'b0);
        run_job("t9", 32'd5, 2'd0, 32'd3, 64'h1000, 64'h8000);
        for (int i = 0; i < 5; i++) check($sformatf("t9 data%0d", i), mem[64'h8000 + 64'(8 * i)], 64'hA3 + 64'(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
